// File: rtl/food_placer.sv
// food_placer: chooses a free playfield cell for new food, trying random cells first and then a raster scan.
// Latency: done comes 3 edges after place_req is accepted at best; worst case 1+3*MAX_TRIES+3*GRID_W*GRID_H cycles.
// Backpressure: none. place_req is dropped while busy=1. Occupancy lookups are fixed-latency, so no handshake is needed.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   place_req            one-cycle request to place new food (accepted only when idle)
//   randX, randY         free-running random coordinates, sampled one per attempt
//   occ_qx, occ_qy       registered occupancy query toward the snake-body lookup
//   occ_hit              lookup answer; it belongs to the query driven two edges earlier
//   busy                 a placement is in progress
//   food_x, food_y       last placed food cell; valid while food_valid=1
//   food_valid           food_x/food_y name a free cell
//   done, fail           one-cycle completion pulses (food placed / grid full)
module food_placer #(
  parameter int GRID_W    = 40,
  parameter int GRID_H    = 30,
  parameter int COORD_W   = 7,
  parameter int MAX_TRIES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               place_req,
  input  logic [COORD_W-1:0] randX,
  input  logic [COORD_W-1:0] randY,
  output logic [COORD_W-1:0] occ_qx,
  output logic [COORD_W-1:0] occ_qy,
  input  logic               occ_hit,
  output logic               busy,
  output logic [COORD_W-1:0] food_x,
  output logic [COORD_W-1:0] food_y,
  output logic               food_valid,
  output logic               done,
  output logic               fail
);

  // State encoding is kept as plain constants so older tools and dumps can decode it.
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SAMPLE   = 3'd1;
  localparam logic [2:0] S_WAIT     = 3'd2;
  localparam logic [2:0] S_CHECK    = 3'd3;
  localparam logic [2:0] S_SCAN_Q   = 3'd4;
  localparam logic [2:0] S_SCAN_W   = 3'd5;
  localparam logic [2:0] S_SCAN_CHK = 3'd6;

  localparam logic [COORD_W-1:0] GRID_W_C = COORD_W'(GRID_W);
  localparam logic [COORD_W-1:0] GRID_H_C = COORD_W'(GRID_H);
  localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(GRID_H - 1);
  // try_cnt holds the number of tries already used up, so this value marks the final try.
  localparam logic [7:0]         TRY_LAST = 8'(MAX_TRIES - 1);

  logic [2:0]         state;
  logic [2:0]         state_n;
  logic [7:0]         try_cnt;
  logic [COORD_W-1:0] scan_x;
  logic [COORD_W-1:0] scan_y;

  // Decoded actions for the current cycle. The sequential block only applies them.
  logic               accept;
  logic               query_en;
  logic [COORD_W-1:0] query_x;
  logic [COORD_W-1:0] query_y;
  logic               try_inc;
  logic               scan_clr;
  logic               scan_adv;
  logic               finish_ok;
  logic               finish_fail;

  logic               rand_in_grid;
  logic               try_last;
  logic               scan_last;

  // Out-of-range samples are rejected. They are never folded into the grid, which
  // would skew the food distribution toward low coordinates.
  assign rand_in_grid = (randX < GRID_W_C) && (randY < GRID_H_C);
  assign try_last     = (try_cnt == TRY_LAST);
  assign scan_last    = (scan_x == X_LAST) && (scan_y == Y_LAST);

  always_comb begin
    state_n     = state;
    accept      = 1'b0;
    query_en    = 1'b0;
    query_x     = scan_x;
    query_y     = scan_y;
    try_inc     = 1'b0;
    scan_clr    = 1'b0;
    scan_adv    = 1'b0;
    finish_ok   = 1'b0;
    finish_fail = 1'b0;

    case (state)
      S_IDLE: begin
        if (place_req) begin
          accept  = 1'b1;
          state_n = S_SAMPLE;
        end
      end

      S_SAMPLE: begin
        if (rand_in_grid) begin
          query_en = 1'b1;
          query_x  = randX;
          query_y  = randY;
          state_n  = S_WAIT;
        end else begin
          // A rejected sample costs a try but no lookup. The next cycle brings a fresh random value.
          try_inc = 1'b1;
          if (try_last) begin
            scan_clr = 1'b1;
            state_n  = S_SCAN_Q;
          end
        end
      end

      // The lookup is registered, so its answer for our query only shows up one cycle later.
      S_WAIT: state_n = S_CHECK;

      S_CHECK: begin
        if (!occ_hit) begin
          finish_ok = 1'b1;
          state_n   = S_IDLE;
        end else begin
          try_inc = 1'b1;
          if (try_last) begin
            scan_clr = 1'b1;
            state_n  = S_SCAN_Q;
          end else begin
            state_n = S_SAMPLE;
          end
        end
      end

      S_SCAN_Q: begin
        query_en = 1'b1;
        state_n  = S_SCAN_W;
      end

      S_SCAN_W: state_n = S_SCAN_CHK;

      S_SCAN_CHK: begin
        if (!occ_hit) begin
          finish_ok = 1'b1;
          state_n   = S_IDLE;
        end else if (scan_last) begin
          // The scan covered every cell and found none free, so the grid is full.
          finish_fail = 1'b1;
          state_n     = S_IDLE;
        end else begin
          scan_adv = 1'b1;
          state_n  = S_SCAN_Q;
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      try_cnt    <= '0;
      scan_x     <= '0;
      scan_y     <= '0;
      occ_qx     <= '0;
      occ_qy     <= '0;
      food_x     <= '0;
      food_y     <= '0;
      food_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fail       <= 1'b0;
    end else begin
      state <= state_n;
      done  <= finish_ok;
      fail  <= finish_fail;

      if (accept) begin
        busy       <= 1'b1;
        food_valid <= 1'b0;
        try_cnt    <= '0;
      end

      if (try_inc) begin
        try_cnt <= try_cnt + 8'd1;
      end

      if (query_en) begin
        occ_qx <= query_x;
        occ_qy <= query_y;
      end

      if (scan_clr) begin
        scan_x <= '0;
        scan_y <= '0;
      end else if (scan_adv) begin
        // Raster order: x advances first, and y advances when x wraps.
        if (scan_x == X_LAST) begin
          scan_x <= '0;
          scan_y <= scan_y + 1'b1;
        end else begin
          scan_x <= scan_x + 1'b1;
        end
      end

      // The query registers still hold the cell whose answer is being checked.
      if (finish_ok) begin
        food_x     <= occ_qx;
        food_y     <= occ_qy;
        food_valid <= 1'b1;
        busy       <= 1'b0;
      end

      if (finish_fail) begin
        busy <= 1'b0;
      end
    end
  end

endmodule
